// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame FSM states and protocol byte codes.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_e;

   localparam logic [7:0] BYTE_E0 = 8'hE0;
   localparam logic [7:0] BYTE_F0 = 8'hF0;
   localparam logic [7:0] BYTE_E1 = 8'hE1;
   localparam logic [7:0] BYTE_AA = 8'hAA;
   localparam logic [7:0] BYTE_FA = 8'hFA;
   localparam logic [7:0] BYTE_FE = 8'hFE;
   localparam logic [7:0] BYTE_EE = 8'hEE;
   localparam logic [7:0] BYTE_00 = 8'h00;
   localparam logic [7:0] BYTE_FF = 8'hFF;

   // Bytes that are protocol chatter (ack, BAT, echo, pause lead-in) rather than key codes.
   function automatic logic is_discard(input logic [7:0] b);
      return (b == BYTE_E1) || (b == BYTE_AA) || (b == BYTE_FA) || (b == BYTE_FE) ||
             (b == BYTE_EE) || (b == BYTE_00) || (b == BYTE_FF);
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length glitch filter for a PS/2 line; emits a falling-edge strobe.
module ps2_line_filter #(
   parameter int FILT_LEN = 8
) (
   input  logic clk_sys,
   input  logic rst_n,
   input  logic line_in,
   output logic fall_stb
);

   localparam int CNT_W = $clog2(FILT_LEN + 1);

   logic             sync_p0;
   logic             sync_p1;
   logic             prev_p2;
   logic             line_filt;
   logic [CNT_W-1:0] run_cnt;

   // The filtered level flips only after FILT_LEN successive samples repeat a level different from it.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0   <= 1'b1;
         sync_p1   <= 1'b1;
         prev_p2   <= 1'b0;
         line_filt <= 1'b0;
         run_cnt   <= '0;
         fall_stb  <= 1'b0;
      end else begin
         sync_p0  <= line_in;
         sync_p1  <= sync_p0;
         prev_p2  <= sync_p1;
         fall_stb <= 1'b0;
         if ((sync_p1 != line_filt) && (sync_p1 == prev_p2)) begin
            if (run_cnt == CNT_W'(FILT_LEN - 1)) begin
               line_filt <= sync_p1;
               fall_stb  <= line_filt & ~sync_p1;
               run_cnt   <= '0;
            end else begin
               run_cnt <= run_cnt + 1'b1;
            end
         end else begin
            run_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: frames bytes, tracks E0/F0 prefixes and emits toggle-flagged key events.
// Optional held-key repeat suppression is enabled by defining PS2_REPEAT_FILTER_EN.
module ps2_key_rx
   import ps2_pkg::*;
#(
   parameter int FILT_LEN = 8,
   parameter int TIMEOUT  = 4096
) (
   input  logic        clk_sys,
   input  logic        I_RESETn,
   input  logic        ps2_clk_in,
   input  logic        ps2_dat_in,
   output logic [10:0] ps2_key,
   output logic        frame_err
);

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   logic       fall_stb;
   logic       dat_p0;
   logic       dat_p1;
   ps2_state_e state;
   logic [2:0] bit_cnt;
   logic [7:0] shift_p1;
   logic       par_p1;
   logic [15:0] idle_cnt;
   logic       ext;
   logic       brk;

   logic       frame_ok;
   logic       is_e0;
   logic       is_f0;
   logic       is_disc;
   logic       suppress;
   logic       emit;

   ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
      .clk_sys  (clk_sys),
      .rst_n    (I_RESETn),
      .line_in  (ps2_clk_in),
      .fall_stb (fall_stb)
   );

   always_ff @(posedge clk_sys or negedge I_RESETn) begin
      if (!I_RESETn) begin
         dat_p0 <= 1'b1;
         dat_p1 <= 1'b1;
      end else begin
         dat_p0 <= ps2_dat_in;
         dat_p1 <= dat_p0;
      end
   end

   // Stop-bit decode: odd weight across data+parity and a high stop bit.
   always_comb begin
      frame_ok = (^{shift_p1, par_p1}) & dat_p1;
      is_e0    = (shift_p1 == BYTE_E0);
      is_f0    = (shift_p1 == BYTE_F0);
      is_disc  = is_discard(shift_p1);
   end

`ifdef PS2_REPEAT_FILTER_EN
   logic [511:0] held;
   logic [8:0]   held_idx;

   assign held_idx = {ext, shift_p1};
   assign suppress = ~brk & held[held_idx];

   always_ff @(posedge clk_sys or negedge I_RESETn) begin
      if (!I_RESETn) begin
         held <= '0;
      end else if (emit) begin
         held[held_idx] <= ~brk;
      end
   end
`else
   assign suppress = 1'b0;
`endif

   assign emit = fall_stb && (state == ST_STOP) && frame_ok &&
                 !is_e0 && !is_f0 && !is_disc && !suppress;

   always_ff @(posedge clk_sys or negedge I_RESETn) begin
      if (!I_RESETn) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shift_p1  <= '0;
         par_p1    <= 1'b0;
         idle_cnt  <= '0;
         ext       <= 1'b0;
         brk       <= 1'b0;
         ps2_key   <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (fall_stb) begin
            idle_cnt <= '0;
            case (state)
               ST_IDLE: begin
                  if (!dat_p1) begin
                     state   <= ST_DATA;
                     bit_cnt <= '0;
                  end
               end
               ST_DATA: begin
                  shift_p1 <= {dat_p1, shift_p1[7:1]};
                  bit_cnt  <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= ST_PARITY;
               end
               ST_PARITY: begin
                  par_p1 <= dat_p1;
                  state  <= ST_STOP;
               end
               default: begin
                  state <= ST_IDLE;
                  if (!frame_ok) begin
                     frame_err <= 1'b1;
                     ext       <= 1'b0;
                     brk       <= 1'b0;
                  end else if (is_e0) begin
                     ext <= 1'b1;
                  end else if (is_f0) begin
                     brk <= 1'b1;
                  end else begin
                     ext <= 1'b0;
                     brk <= 1'b0;
                     if (emit) ps2_key <= {~ps2_key[10], ~brk, ext, shift_p1};
                  end
               end
            endcase
         end else begin
            if (idle_cnt != 16'hFFFF) idle_cnt <= idle_cnt + 1'b1;
            // A stalled frame is abandoned; an edge in the same cycle wins (handled above).
            if ((state != ST_IDLE) && (idle_cnt == TO_LAST)) begin
               state     <= ST_IDLE;
               frame_err <= 1'b1;
               ext       <= 1'b0;
               brk       <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed self-checking bench for ps2_key_rx; expected key words are hand-computed per frame.
module tb_ps2_key_rx;

   logic        clk_sys;
   logic        I_RESETn;
   logic        ps2_clk_in;
   logic        ps2_dat_in;
   logic [10:0] ps2_key;
   logic        frame_err;

   int n_checks = 0;
   int n_errors = 0;
   int evt_cnt  = 0;
   int err_cnt  = 0;
   logic prev_t = 1'b0;

`ifdef PS2_REPEAT_FILTER_EN
   localparam int REP_EVT = 1;
`else
   localparam int REP_EVT = 3;
`endif

   ps2_key_rx #(.FILT_LEN(8), .TIMEOUT(4096)) dut (
      .clk_sys    (clk_sys),
      .I_RESETn   (I_RESETn),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .ps2_key    (ps2_key),
      .frame_err  (frame_err)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) begin
      if (I_RESETn) begin
         if (frame_err) err_cnt <= err_cnt + 1;
         if (ps2_key[10] != prev_t) evt_cnt <= evt_cnt + 1;
      end
      prev_t <= ps2_key[10];
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic check_key(input string tag, input logic [10:0] obs, input logic [10:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Sends the first nbits bits of an 11-bit frame; optional 8-cycle low glitch in one bit's high phase.
   task automatic send_frame(input logic [7:0] b, input logic par_flip, input int nbits, input int glitch_at);
      logic [10:0] fr;
      fr = {1'b1, (~^b) ^ par_flip, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_dat_in = fr[i];
         wait_cyc(20);
         if (i == glitch_at) begin
            ps2_clk_in = 1'b0;
            wait_cyc(8);
            ps2_clk_in = 1'b1;
            wait_cyc(12);
         end
         ps2_clk_in = 1'b0;
         wait_cyc(40);
         ps2_clk_in = 1'b1;
         wait_cyc(20);
      end
      ps2_dat_in = 1'b1;
      wait_cyc(30);
   endtask

   initial begin
      int   e0;
      int   r0;
      logic exp_t;

      I_RESETn   = 1'b0;
      ps2_clk_in = 1'b1;
      ps2_dat_in = 1'b1;
      exp_t      = 1'b0;
      wait_cyc(5);
      check_key("reset_key", ps2_key, 11'h000);
      check_int("reset_err", int'(frame_err), 0);
      I_RESETn = 1'b1;
      wait_cyc(30);

      e0 = evt_cnt; r0 = err_cnt;
      send_frame(8'h1C, 1'b0, 11, -1);
      exp_t = ~exp_t;
      check_key("make_1c", ps2_key, {exp_t, 1'b1, 1'b0, 8'h1C});
      check_int("make_1c_evt", evt_cnt - e0, 1);
      check_int("make_1c_err", err_cnt - r0, 0);

      e0 = evt_cnt;
      send_frame(8'hE0, 1'b0, 11, -1);
      check_int("after_e0_evt", evt_cnt - e0, 0);
      send_frame(8'hF0, 1'b0, 11, -1);
      check_int("after_f0_evt", evt_cnt - e0, 0);
      send_frame(8'h75, 1'b0, 11, -1);
      exp_t = ~exp_t;
      check_key("ext_brk_75", ps2_key, {exp_t, 1'b0, 1'b1, 8'h75});
      check_int("ext_brk_75_evt", evt_cnt - e0, 1);

      e0 = evt_cnt; r0 = err_cnt;
      send_frame(8'h29, 1'b1, 11, -1);
      check_int("bad_par_err", err_cnt - r0, 1);
      check_key("bad_par_key", ps2_key, {exp_t, 1'b0, 1'b1, 8'h75});
      send_frame(8'h29, 1'b0, 11, -1);
      exp_t = ~exp_t;
      check_key("good_29", ps2_key, {exp_t, 1'b1, 1'b0, 8'h29});
      check_int("good_29_evt", evt_cnt - e0, 1);

      e0 = evt_cnt; r0 = err_cnt;
      send_frame(8'h12, 1'b0, 5, -1);
      wait_cyc(4200);
      check_int("timeout_err", err_cnt - r0, 1);
      send_frame(8'h5A, 1'b0, 11, -1);
      exp_t = ~exp_t;
      check_key("post_timeout_5a", ps2_key, {exp_t, 1'b1, 1'b0, 8'h5A});
      check_int("post_timeout_evt", evt_cnt - e0, 1);

      e0 = evt_cnt;
      send_frame(8'hE0, 1'b0, 11, -1);
      send_frame(8'hAA, 1'b0, 11, -1);
      check_int("discard_aa_evt", evt_cnt - e0, 0);
      send_frame(8'h1C, 1'b0, 11, -1);
      exp_t = ~exp_t;
      check_key("aa_clears_ext", ps2_key, {exp_t, 1'b1, 1'b0, 8'h1C});

      e0 = evt_cnt;
      for (int k = 0; k < 3; k++) send_frame(8'h6B, 1'b0, 11, -1);
      if (REP_EVT[0]) exp_t = ~exp_t;
      check_int("repeat_6b_evt", evt_cnt - e0, REP_EVT);
      check_key("repeat_6b_key", ps2_key, {exp_t, 1'b1, 1'b0, 8'h6B});
      e0 = evt_cnt;
      send_frame(8'hF0, 1'b0, 11, -1);
      send_frame(8'h6B, 1'b0, 11, -1);
      exp_t = ~exp_t;
      check_int("release_6b_evt", evt_cnt - e0, 1);
      check_key("release_6b_key", ps2_key, {exp_t, 1'b0, 1'b0, 8'h6B});

      e0 = evt_cnt; r0 = err_cnt;
      send_frame(8'h33, 1'b0, 11, 4);
      exp_t = ~exp_t;
      check_key("glitch_33", ps2_key, {exp_t, 1'b1, 1'b0, 8'h33});
      check_int("glitch_33_err", err_cnt - r0, 0);
      check_int("glitch_33_evt", evt_cnt - e0, 1);

      send_frame(8'h1C, 1'b0, 5, -1);
      I_RESETn = 1'b0;
      wait_cyc(3);
      check_key("midframe_rst_key", ps2_key, 11'h000);
      check_int("midframe_rst_err", int'(frame_err), 0);
      I_RESETn = 1'b1;
      exp_t = 1'b0;
      e0 = evt_cnt; r0 = err_cnt;
      wait_cyc(5000);
      check_int("post_rst_evt", evt_cnt - e0, 0);
      check_int("post_rst_err", err_cnt - r0, 0);
      send_frame(8'h1C, 1'b0, 11, -1);
      exp_t = ~exp_t;
      check_key("post_rst_1c", ps2_key, {exp_t, 1'b1, 1'b0, 8'h1C});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
